// File: rtl/periph_timer_slave_pkg.sv
// Shared constants for the memory-mapped timer peripheral: register word
// offsets inside the window, TCON bit positions and the default base address.
package periph_timer_slave_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  localparam logic [2:0] OFS_TH      = 3'd0;
  localparam logic [2:0] OFS_TL      = 3'd1;
  localparam logic [2:0] OFS_TCON    = 3'd2;
  localparam logic [2:0] OFS_SYSTICK = 3'd5;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

endpackage

// File: rtl/periph_timer_slave_prescaler.sv
// Clock divider for the timer: while enabled it counts clk cycles and emits a
// one-cycle tick every PRESCALE enabled cycles. Disabling freezes the count
// rather than clearing it, so a paused timer resumes mid-period.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_b,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] r_pcnt;

  assign tick = en && (r_pcnt == LAST);

  // Count enabled cycles, wrapping to zero on the cycle that produces a tick.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      r_pcnt <= '0;
    end else if (en) begin
      r_pcnt <= (r_pcnt == LAST) ? 16'd0 : r_pcnt + 16'd1;
    end
  end

endmodule

// File: rtl/periph_timer_slave.sv
// Timer peripheral on the MEM-stage load/store bus: reloadable up-counter
// TH/TL, control/status TCON, free-running SYSTICK and a level interrupt.
module periph_timer_slave
  import periph_timer_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irqout
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic [31:0] r_systick;

  logic [31:0] w_offset;
  logic        w_inWin;
  logic [2:0]  w_sel;
  logic        w_wr;
  logic        w_wrTh;
  logic        w_wrTl;
  logic        w_wrTcon;
  logic        w_tick;
  logic        w_ovf;
  logic [2:0]  w_tconNext;

  // Window decode works on the offset so a base that is not 32-byte aligned
  // still maps its first word to TH; the low two address bits are dropped.
  assign w_offset = addr - BASE_ADDR;
  assign w_inWin  = (w_offset < 32'd32);
  assign w_sel    = w_offset[4:2];

  assign hit      = w_inWin && (mem_read || mem_write);
  assign w_wr     = hit && mem_write;
  assign w_wrTh   = w_wr && (w_sel == OFS_TH);
  assign w_wrTl   = w_wr && (w_sel == OFS_TL);
  assign w_wrTcon = w_wr && (w_sel == OFS_TCON);

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset_b(reset_b),
    .en     (r_tcon[TCON_EN]),
    .tick   (w_tick)
  );

  // A software store to TL suppresses the overflow, so it also cannot raise
  // the status bit on that cycle.
  assign w_ovf = w_tick && (r_tl == 32'hFFFF_FFFF) && !w_wrTl;

  assign irqout = r_tcon[TCON_IE] && r_tcon[TCON_ST];

  // Load data is a pure function of the address and pre-edge register state.
  always_comb begin
    rdata = '0;
    if (w_inWin) begin
      case (w_sel)
        OFS_TH:      rdata = r_th;
        OFS_TL:      rdata = r_tl;
        OFS_TCON:    rdata = {29'd0, r_tcon};
        OFS_SYSTICK: rdata = r_systick;
        default:     rdata = '0;
      endcase
    end
  end

  // Next TCON: software write first, then a hardware status set on overflow
  // wins over a software clear so no interrupt is dropped.
  always_comb begin
    w_tconNext = r_tcon;
    if (w_wrTcon) begin
      w_tconNext = wdata[2:0];
    end
    if (w_ovf && r_tcon[TCON_IE]) begin
      w_tconNext[TCON_ST] = 1'b1;
    end
  end

  // Reload register and counter; a TL store beats both increment and reload,
  // and a reload uses TH from before any same-cycle TH store.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      r_th <= '0;
      r_tl <= '0;
    end else begin
      if (w_wrTh) begin
        r_th <= wdata;
      end
      if (w_wrTl) begin
        r_tl <= wdata;
      end else if (w_ovf) begin
        r_tl <= r_th;
      end else if (w_tick) begin
        r_tl <= r_tl + 32'd1;
      end
    end
  end

  // Control/status register update.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      r_tcon <= '0;
    end else begin
      r_tcon <= w_tconNext;
    end
  end

  // Free-running cycle counter, not writable by software.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      r_systick <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
    end
  end

endmodule

// File: tb/tb_periph_timer_slave.sv
// Bench for periph_timer_slave: two instances (PRESCALE 1 and 4) share one bus
// and are checked against a cycle-level behavioural model of the register map.
module tb_periph_timer_slave;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset_b = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] rdata1, rdata4;
  logic        hit1, hit4, irq1, irq4;

  int total = 0;
  int bad = 0;

  logic [31:0] m_th [2];
  logic [31:0] m_tl [2];
  logic [2:0]  m_tcon [2];
  int          m_pcnt [2];
  int          m_pre [2] = '{1, 4};
  logic [31:0] m_sys;

  always #5 clk = ~clk;

  periph_timer_slave #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
    .clk(clk), .reset_b(reset_b), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .rdata(rdata1), .hit(hit1), .irqout(irq1)
  );

  periph_timer_slave #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
    .clk(clk), .reset_b(reset_b), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .rdata(rdata4), .hit(hit4), .irqout(irq4)
  );

  // Reference model helpers
  function automatic logic mInWin(logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd31);
  endfunction

  function automatic logic [31:0] mRead(int i, logic [31:0] a);
    logic [31:0] word;
    if (!mInWin(a)) return 32'd0;
    word = (a - BASE) / 4;
    case (word)
      32'd0:   return m_th[i];
      32'd1:   return m_tl[i];
      32'd2:   return {29'd0, m_tcon[i]};
      32'd5:   return m_sys;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic mIrq(int i);
    return m_tcon[i][1] && m_tcon[i][2];
  endfunction

  function automatic logic mHit();
    return mInWin(addr) && (mem_read || mem_write);
  endfunction

  // One clock edge of the specified behaviour, using the current bus inputs
  function automatic void mStep();
    logic        wr, tick, ovfIrq;
    logic [31:0] word, nTh, nTl;
    logic [2:0]  nTcon;
    wr = mem_write && mInWin(addr);
    word = (addr - BASE) / 4;
    for (int i = 0; i < 2; i++) begin
      if (reset_b) begin
        m_th[i] = 0; m_tl[i] = 0; m_tcon[i] = 0; m_pcnt[i] = 0;
      end else begin
        tick = m_tcon[i][0] && (m_pcnt[i] == m_pre[i] - 1);
        if (m_tcon[i][0]) m_pcnt[i] = (m_pcnt[i] + 1) % m_pre[i];
        nTh = m_th[i]; nTl = m_tl[i]; nTcon = m_tcon[i]; ovfIrq = 1'b0;
        if (tick) begin
          if (m_tl[i] == 32'hFFFF_FFFF) begin
            nTl = m_th[i];
            ovfIrq = m_tcon[i][1];
          end else begin
            nTl = m_tl[i] + 1;
          end
        end
        if (wr) begin
          case (word)
            32'd0: nTh = wdata;
            32'd1: begin nTl = wdata; ovfIrq = 1'b0; end
            32'd2: nTcon = wdata[2:0];
            default: ;
          endcase
        end
        if (ovfIrq) nTcon[2] = 1'b1;
        m_th[i] = nTh; m_tl[i] = nTl; m_tcon[i] = nTcon;
      end
    end
    m_sys = reset_b ? 32'd0 : m_sys + 32'd1;
  endfunction

  task automatic doCycle();
    mStep();
    @(posedge clk);
    #1;
  endtask

  task automatic setRead(input logic [31:0] ofs);
    addr = BASE + ofs;
    mem_read = 1'b1;
    mem_write = 1'b0;
    #1;
  endtask

  task automatic writeReg(input logic [31:0] ofs, input logic [31:0] data);
    addr = BASE + ofs;
    wdata = data;
    mem_write = 1'b1;
    mem_read = 1'b0;
    doCycle();
    mem_write = 1'b0;
  endtask

  task automatic pulseReset();
    mem_read = 1'b0; mem_write = 1'b0;
    reset_b = 1'b1;
    doCycle();
    reset_b = 1'b0;
  endtask

  task automatic test_reset();
    mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    reset_b = 1'b1;
    doCycle();
    doCycle();
    reset_b = 1'b0;
    #1;
    total++; if (rdata1 !== 32'd0) begin bad++; $display("[TB] FAIL reset_rdata_addr0 got=%h want=%h", rdata1, 32'd0); end
    total++; if (hit1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_hit got=%b want=0", hit1); end
    total++; if (irq1 !== 1'b0 || irq4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq got=%b/%b want=0/0", irq1, irq4); end
    for (int k = 0; k < 4; k++) begin
      setRead((k == 3) ? 32'h14 : 32'(k * 4));
      total++; if (rdata1 !== 32'd0 || rdata4 !== 32'd0) begin bad++; $display("[TB] FAIL reset_reg%0d got=%h/%h want=0", k, rdata1, rdata4); end
    end
    mem_read = 1'b0;
  endtask

  task automatic test_overflow_irq();
    writeReg(32'h0, 32'hFFFF_FFFC);
    writeReg(32'h4, 32'hFFFF_FFFE);
    writeReg(32'h8, 32'h3);
    setRead(32'h4);
    total++; if (rdata1 !== 32'hFFFF_FFFE) begin bad++; $display("[TB] FAIL ovf_tl_start got=%h want=%h", rdata1, 32'hFFFF_FFFE); end
    doCycle();
    total++; if (rdata1 !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL ovf_tl_max got=%h want=%h", rdata1, 32'hFFFF_FFFF); end
    total++; if (irq1 !== 1'b0) begin bad++; $display("[TB] FAIL ovf_irq_early got=%b want=0", irq1); end
    doCycle();
    total++; if (rdata1 !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL ovf_tl_reload got=%h want=%h", rdata1, 32'hFFFF_FFFC); end
    total++; if (irq1 !== 1'b1) begin bad++; $display("[TB] FAIL ovf_irq got=%b want=1", irq1); end
    total++; if (rdata4 !== mRead(1, addr)) begin bad++; $display("[TB] FAIL ovf_tl_p4 got=%h want=%h", rdata4, mRead(1, addr)); end
    setRead(32'h8);
    total++; if (rdata1 !== 32'h7) begin bad++; $display("[TB] FAIL ovf_tcon got=%h want=%h", rdata1, 32'h7); end
    mem_read = 1'b0;
  endtask

  task automatic test_irq_clear();
    writeReg(32'h8, 32'h3);
    total++; if (irq1 !== 1'b0) begin bad++; $display("[TB] FAIL clr_irq got=%b want=0", irq1); end
    for (int k = 1; k <= 3; k++) begin
      doCycle();
      total++; if (irq1 !== (k == 3)) begin bad++; $display("[TB] FAIL clr_reassert_c%0d got=%b want=%b", k, irq1, (k == 3)); end
      total++; if (irq4 !== mIrq(1)) begin bad++; $display("[TB] FAIL clr_irq_p4_c%0d got=%b want=%b", k, irq4, mIrq(1)); end
    end
  endtask

  task automatic test_prescale();
    pulseReset();
    writeReg(32'h4, 32'h0);
    writeReg(32'h8, 32'h1);
    repeat (12) doCycle();
    setRead(32'h4);
    total++; if (rdata4 !== 32'd3) begin bad++; $display("[TB] FAIL pre_run_p4 got=%h want=%h", rdata4, 32'd3); end
    total++; if (rdata1 !== 32'd12) begin bad++; $display("[TB] FAIL pre_run_p1 got=%h want=%h", rdata1, 32'd12); end
    writeReg(32'h8, 32'h0);
    repeat (5) doCycle();
    setRead(32'h4);
    total++; if (rdata4 !== 32'd3) begin bad++; $display("[TB] FAIL pre_hold_p4 got=%h want=%h", rdata4, 32'd3); end
    total++; if (rdata1 !== 32'd13) begin bad++; $display("[TB] FAIL pre_hold_p1 got=%h want=%h", rdata1, 32'd13); end
    writeReg(32'h8, 32'h1);
    setRead(32'h4);
    doCycle();
    doCycle();
    total++; if (rdata4 !== 32'd3) begin bad++; $display("[TB] FAIL pre_resume2 got=%h want=%h", rdata4, 32'd3); end
    doCycle();
    total++; if (rdata4 !== 32'd4) begin bad++; $display("[TB] FAIL pre_resume3 got=%h want=%h", rdata4, 32'd4); end
    total++; if (rdata1 !== 32'd16) begin bad++; $display("[TB] FAIL pre_resume_p1 got=%h want=%h", rdata1, 32'd16); end
    mem_read = 1'b0;
  endtask

  task automatic test_simultaneous();
    pulseReset();
    writeReg(32'h0, 32'h100);
    writeReg(32'h4, 32'hFFFF_FFFE);
    writeReg(32'h8, 32'h3);
    doCycle();
    writeReg(32'h4, 32'h10);
    setRead(32'h4);
    total++; if (rdata1 !== 32'h10) begin bad++; $display("[TB] FAIL sim_tl_store got=%h want=%h", rdata1, 32'h10); end
    setRead(32'h8);
    total++; if (rdata1 !== 32'h3) begin bad++; $display("[TB] FAIL sim_tl_store_tcon got=%h want=%h", rdata1, 32'h3); end
    writeReg(32'h4, 32'hFFFF_FFFF);
    writeReg(32'h8, 32'h3);
    setRead(32'h8);
    total++; if (rdata1 !== 32'h7) begin bad++; $display("[TB] FAIL sim_tcon_ovf got=%h want=%h", rdata1, 32'h7); end
    total++; if (rdata4 !== mRead(1, addr)) begin bad++; $display("[TB] FAIL sim_tcon_p4 got=%h want=%h", rdata4, mRead(1, addr)); end
    setRead(32'h4);
    total++; if (rdata1 !== 32'h100) begin bad++; $display("[TB] FAIL sim_tcon_tl got=%h want=%h", rdata1, 32'h100); end
    writeReg(32'h4, 32'hFFFF_FFFF);
    writeReg(32'h0, 32'h55);
    setRead(32'h4);
    total++; if (rdata1 !== 32'h100) begin bad++; $display("[TB] FAIL sim_th_ovf_tl got=%h want=%h", rdata1, 32'h100); end
    setRead(32'h0);
    total++; if (rdata1 !== 32'h55) begin bad++; $display("[TB] FAIL sim_th_ovf_th got=%h want=%h", rdata1, 32'h55); end
    writeReg(32'h8, 32'h0);
    setRead(32'h4);
    total++; if (rdata1 !== 32'h101) begin bad++; $display("[TB] FAIL sim_dis_tick got=%h want=%h", rdata1, 32'h101); end
    total++; if (irq1 !== 1'b0) begin bad++; $display("[TB] FAIL sim_dis_irq got=%b want=0", irq1); end
    doCycle();
    total++; if (rdata1 !== 32'h101) begin bad++; $display("[TB] FAIL sim_dis_hold got=%h want=%h", rdata1, 32'h101); end
    total++; if (rdata4 !== mRead(1, addr)) begin bad++; $display("[TB] FAIL sim_dis_p4 got=%h want=%h", rdata4, mRead(1, addr)); end
    mem_read = 1'b0;
  endtask

  task automatic test_systick_window();
    logic [31:0] v1;
    setRead(32'h14);
    v1 = rdata1;
    total++; if (rdata1 !== m_sys) begin bad++; $display("[TB] FAIL sys_value got=%h want=%h", rdata1, m_sys); end
    repeat (5) doCycle();
    total++; if (rdata1 - v1 !== 32'd5) begin bad++; $display("[TB] FAIL sys_delta got=%0d want=5", rdata1 - v1); end
    setRead(32'h16);
    total++; if (rdata4 !== m_sys) begin bad++; $display("[TB] FAIL sys_lowbits got=%h want=%h", rdata4, m_sys); end
    setRead(32'h20);
    total++; if (hit1 !== 1'b0 || rdata1 !== 32'd0) begin bad++; $display("[TB] FAIL win_above got=%b/%h want=0/0", hit1, rdata1); end
    addr = BASE - 32'd4;
    #1;
    total++; if (hit4 !== 1'b0 || rdata4 !== 32'd0) begin bad++; $display("[TB] FAIL win_below got=%b/%h want=0/0", hit4, rdata4); end
    setRead(32'h0C);
    total++; if (hit1 !== 1'b1 || rdata1 !== 32'd0) begin bad++; $display("[TB] FAIL win_hole got=%b/%h want=1/0", hit1, rdata1); end
    writeReg(32'h14, 32'h0);
    setRead(32'h14);
    total++; if (rdata1 !== m_sys) begin bad++; $display("[TB] FAIL sys_ro got=%h want=%h", rdata1, m_sys); end
    mem_read = 1'b0;
  endtask

  task automatic test_reset_midcount();
    writeReg(32'h0, 32'h0);
    writeReg(32'h4, 32'hFFFF_FFFE);
    writeReg(32'h8, 32'h3);
    doCycle();
    doCycle();
    total++; if (irq1 !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_pre_irq got=%b want=1", irq1); end
    pulseReset();
    total++; if (irq1 !== 1'b0 || irq4 !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_irq got=%b/%b want=0/0", irq1, irq4); end
    for (int k = 0; k < 4; k++) begin
      setRead((k == 3) ? 32'h14 : 32'(k * 4));
      total++; if (rdata1 !== 32'd0 || rdata4 !== 32'd0) begin bad++; $display("[TB] FAIL rst_mid_reg%0d got=%h/%h want=0", k, rdata1, rdata4); end
    end
    mem_read = 1'b0;
  endtask

  task automatic test_random();
    int op, sel;
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 3);
      mem_read = (op == 1) || (op == 3);
      mem_write = (op == 2) || (op == 3);
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      else addr = BASE + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3));
      sel = $urandom_range(0, 3);
      case (sel)
        0: wdata = 32'hFFFF_FFFF;
        1: wdata = 32'hFFFF_FFFD;
        2: wdata = 32'($urandom_range(0, 7));
        default: wdata = $urandom;
      endcase
      #1;
      total++; if (rdata1 !== mRead(0, addr)) begin bad++; $display("[TB] FAIL rnd_rdata1 n=%0d got=%h want=%h", n, rdata1, mRead(0, addr)); end
      total++; if (rdata4 !== mRead(1, addr)) begin bad++; $display("[TB] FAIL rnd_rdata4 n=%0d got=%h want=%h", n, rdata4, mRead(1, addr)); end
      total++; if (hit1 !== mHit() || hit4 !== mHit()) begin bad++; $display("[TB] FAIL rnd_hit n=%0d got=%b/%b want=%b", n, hit1, hit4, mHit()); end
      total++; if (irq1 !== mIrq(0) || irq4 !== mIrq(1)) begin bad++; $display("[TB] FAIL rnd_irq n=%0d got=%b/%b want=%b/%b", n, irq1, irq4, mIrq(0), mIrq(1)); end
      doCycle();
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_overflow_irq();
    test_irq_clear();
    test_prescale();
    test_simultaneous();
    test_systick_window();
    test_reset_midcount();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
